// File: rtl/exe_wb_pipe.sv
// exe_wb_pipe: per-lane 2-entry EXE->WB result buffers.
// Each lane is an independent FIFO of {rd, rs1, rs2, data}; state updates on
// the falling clock edge with a synchronous active-low reset.
// Optional feature macro: EXE_WB_PIPE_FWD_EN enables the head-entry forwarding
// lookup (fwd_hit/fwd_data); when undefined, those outputs are tied to zero.
module exe_wb_pipe #(
    parameter int unsigned LANES = 4,
    parameter int unsigned DW    = 32,
    parameter int unsigned AW    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [LANES-1:0]      in_valid,
    output logic [LANES-1:0]      in_ready,
    input  logic [LANES*AW-1:0]   in_rd,
    input  logic [LANES*AW-1:0]   in_rs1,
    input  logic [LANES*AW-1:0]   in_rs2,
    input  logic [LANES*DW-1:0]   in_data,
    input  logic [LANES-1:0]      flush,
    output logic [LANES-1:0]      out_valid,
    input  logic [LANES-1:0]      out_ready,
    output logic [LANES*AW-1:0]   out_rd,
    output logic [LANES*AW-1:0]   out_rs1,
    output logic [LANES*AW-1:0]   out_rs2,
    output logic [LANES*DW-1:0]   out_data,
    input  logic [AW-1:0]         fwd_rs,
    output logic                  fwd_hit,
    output logic [DW-1:0]         fwd_data
);

    localparam int unsigned EW = 3*AW + DW;

    logic [EW-1:0]    mem  [LANES][2];
    logic [1:0]       cnt  [LANES];
    logic             wptr [LANES];
    logic             rptr [LANES];
    logic [EW-1:0]    head [LANES];
    logic [LANES-1:0] push;
    logic [LANES-1:0] pop;

    // Handshake decode and head-entry presentation from registered state only
    always_comb begin
        in_ready  = '0;
        out_valid = '0;
        out_rd    = '0;
        out_rs1   = '0;
        out_rs2   = '0;
        out_data  = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            in_ready[i]  = rst_n && (cnt[i] != 2'd2);
            out_valid[i] = rst_n && (cnt[i] != 2'd0);
            head[i]      = out_valid[i] ? mem[i][rptr[i]] : '0;
            out_rd  [i*AW +: AW] = head[i][EW-1      -: AW];
            out_rs1 [i*AW +: AW] = head[i][EW-1-AW   -: AW];
            out_rs2 [i*AW +: AW] = head[i][EW-1-2*AW -: AW];
            out_data[i*DW +: DW] = head[i][DW-1:0];
        end
        push = in_valid & in_ready;
        pop  = out_valid & out_ready;
    end

    // Per-lane FIFO state; reset beats flush, flush beats push/pop
    always_ff @(negedge clk) begin
        for (int unsigned i = 0; i < LANES; i++) begin
            if (!rst_n) begin
                cnt[i]    <= '0;
                wptr[i]   <= 1'b0;
                rptr[i]   <= 1'b0;
                mem[i][0] <= '0;
                mem[i][1] <= '0;
            end else if (flush[i]) begin
                // Realign the read pointer so the next push lands at the head
                cnt[i]  <= '0;
                rptr[i] <= wptr[i];
            end else begin
                if (push[i]) begin
                    mem[i][wptr[i]] <= {in_rd[i*AW +: AW], in_rs1[i*AW +: AW],
                                        in_rs2[i*AW +: AW], in_data[i*DW +: DW]};
                    wptr[i] <= ~wptr[i];
                end
                if (pop[i]) begin
                    rptr[i] <= ~rptr[i];
                end
                case ({push[i], pop[i]})
                    2'b10:   cnt[i] <= cnt[i] + 2'd1;
                    2'b01:   cnt[i] <= cnt[i] - 2'd1;
                    default: cnt[i] <= cnt[i];
                endcase
            end
        end
    end

`ifdef EXE_WB_PIPE_FWD_EN
    // Forward from the lowest-indexed lane whose head writes fwd_rs
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (!fwd_hit && out_valid[i] && (fwd_rs != '0) &&
                (out_rd[i*AW +: AW] == fwd_rs)) begin
                fwd_hit  = 1'b1;
                fwd_data = out_data[i*DW +: DW];
            end
        end
    end
`else
    logic unused_fwd_rs;
    assign unused_fwd_rs = ^fwd_rs;
    assign fwd_hit       = 1'b0;
    assign fwd_data      = '0;
`endif

endmodule

// File: tb/tb_exe_wb_pipe.sv
// Testbench for exe_wb_pipe: directed vectors on a default-sized instance and
// queue-scoreboarded random traffic on a LANES=6, DW=16 instance.
module tb_exe_wb_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- instance A: default parameters ----------------
    logic [3:0]  a_in_valid = '0, a_in_ready, a_flush = '0, a_out_valid, a_out_ready = '0;
    logic [15:0] a_in_rd = '0, a_in_rs1 = '0, a_in_rs2 = '0;
    logic [15:0] a_out_rd, a_out_rs1, a_out_rs2;
    logic [127:0] a_in_data = '0, a_out_data;
    logic [3:0]  a_fwd_rs = '0;
    logic        a_fwd_hit;
    logic [31:0] a_fwd_data;

    exe_wb_pipe dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_rd(a_in_rd), .in_rs1(a_in_rs1), .in_rs2(a_in_rs2), .in_data(a_in_data),
        .flush(a_flush),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_rd(a_out_rd), .out_rs1(a_out_rs1), .out_rs2(a_out_rs2), .out_data(a_out_data),
        .fwd_rs(a_fwd_rs), .fwd_hit(a_fwd_hit), .fwd_data(a_fwd_data)
    );

    // ---------------- instance B: LANES=6, DW=16 ----------------
    logic        rst_b_n = 1'b0;
    logic [5:0]  b_in_valid = '0, b_in_ready, b_flush = '0, b_out_valid, b_out_ready = '0;
    logic [23:0] b_in_rd = '0, b_in_rs1 = '0, b_in_rs2 = '0;
    logic [23:0] b_out_rd, b_out_rs1, b_out_rs2;
    logic [95:0] b_in_data = '0, b_out_data;
    logic [3:0]  b_fwd_rs = '0;
    logic        b_fwd_hit;
    logic [15:0] b_fwd_data;

    exe_wb_pipe #(.LANES(6), .DW(16), .AW(4)) dut_b (
        .clk(clk), .rst_n(rst_b_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_rd(b_in_rd), .in_rs1(b_in_rs1), .in_rs2(b_in_rs2), .in_data(b_in_data),
        .flush(b_flush),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_rd(b_out_rd), .out_rs1(b_out_rs1), .out_rs2(b_out_rs2), .out_data(b_out_data),
        .fwd_rs(b_fwd_rs), .fwd_hit(b_fwd_hit), .fwd_data(b_fwd_data)
    );

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_a(input int l, input logic [3:0] rd, input logic [3:0] rs1,
                         input logic [3:0] rs2, input logic [31:0] d);
        a_in_rd [l*4 +: 4]   = rd;
        a_in_rs1[l*4 +: 4]   = rs1;
        a_in_rs2[l*4 +: 4]   = rs2;
        a_in_data[l*32 +: 32] = d;
    endtask

    logic [27:0] sb [6][$];
    logic [27:0] exp_e;
    logic [27:0] got_e;

    initial begin
        // ---------- reset ----------
        tick();
        tick();
        check("rst_out_valid", a_out_valid, 4'h0);
        check("rst_in_ready", a_in_ready, 4'h0);
        check("rst_out_data", a_out_data, 128'h0);
        check("rst_fwd_hit", a_fwd_hit, 1'b0);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", a_in_ready, 4'hF);
        tick();

        // ---------- lane 3 fill, overflow, ordered drain ----------
        set_a(3, 4'd5, 4'd1, 4'd2, 32'hDEADBEEF);
        a_in_valid = 4'b1000;
        tick();
        check("l3_valid", a_out_valid, 4'b1000);
        check("l3_rd", a_out_rd[15:12], 4'd5);
        check("l3_rs1", a_out_rs1[15:12], 4'd1);
        check("l3_rs2", a_out_rs2[15:12], 4'd2);
        check("l3_data", a_out_data[127:96], 32'hDEADBEEF);
        check("l3_ready1", a_in_ready, 4'hF);
        set_a(3, 4'd6, 4'd3, 4'd4, 32'h12345678);
        tick();
        check("l3_full", a_in_ready, 4'b0111);
        check("l3_head_kept", a_out_rd[15:12], 4'd5);
        set_a(3, 4'd9, 4'd9, 4'd9, 32'h00000BAD);
        tick();
        check("l3_ovf_ignored", a_out_data[127:96], 32'hDEADBEEF);
        a_in_valid = 4'b0000;
        a_out_ready = 4'b1000;
        tick();
        check("l3_pop1_rd", a_out_rd[15:12], 4'd6);
        check("l3_pop1_data", a_out_data[127:96], 32'h12345678);
        tick();
        check("l3_empty", a_out_valid, 4'b0000);
        check("l3_zero_data", a_out_data[127:96], 32'h0);
        check("l3_zero_rd", a_out_rd[15:12], 4'h0);
        a_out_ready = 4'b0000;

        // ---------- lane 1 simultaneous push and pop at count 1 ----------
        set_a(1, 4'd3, 4'd0, 4'd0, 32'h0000AAAA);
        a_in_valid = 4'b0010;
        tick();
        check("l1_first", a_out_data[63:32], 32'h0000AAAA);
        set_a(1, 4'd4, 4'd0, 4'd0, 32'h0000BBBB);
        a_out_ready = 4'b0010;
        tick();
        check("l1_pp_valid", a_out_valid, 4'b0010);
        check("l1_pp_data", a_out_data[63:32], 32'h0000BBBB);
        check("l1_pp_ready", a_in_ready, 4'hF);
        a_in_valid = 4'b0000;
        tick();
        check("l1_pp_count1", a_out_valid, 4'b0000);
        a_out_ready = 4'b0000;

        // ---------- lane 0 flush overrides push ----------
        set_a(0, 4'd1, 4'd0, 4'd0, 32'h1);
        a_in_valid = 4'b0001;
        tick();
        set_a(0, 4'd2, 4'd0, 4'd0, 32'h2);
        tick();
        check("l0_full", a_in_ready, 4'b1110);
        a_flush = 4'b0001;
        tick();
        check("l0_flush_valid", a_out_valid, 4'b0000);
        check("l0_flush_ready", a_in_ready, 4'hF);
        // count 1: flush with push and pop at the same edge still empties
        a_flush = 4'b0000;
        set_a(0, 4'd3, 4'd0, 4'd0, 32'h3);
        tick();
        a_flush = 4'b0001;
        a_out_ready = 4'b0001;
        set_a(0, 4'd4, 4'd0, 4'd0, 32'h4);
        tick();
        check("l0_flush_pp", a_out_valid, 4'b0000);
        a_flush = 4'b0000;
        a_out_ready = 4'b0000;
        // after flush the lane behaves normally
        set_a(0, 4'd8, 4'd0, 4'd0, 32'h88);
        tick();
        a_in_valid = 4'b0000;
        check("l0_post_flush", a_out_data[31:0], 32'h88);
        a_out_ready = 4'b0001;
        tick();
        a_out_ready = 4'b0000;

        // ---------- forwarding ----------
        set_a(2, 4'd7, 4'd0, 4'd0, 32'h11);
        set_a(0, 4'd7, 4'd0, 4'd0, 32'h22);
        a_in_valid = 4'b0101;
        tick();
        a_in_valid = 4'b0000;
        a_fwd_rs = 4'd7;
        #1;
`ifdef EXE_WB_PIPE_FWD_EN
        check("fwd_hit", a_fwd_hit, 1'b1);
        check("fwd_data_lo", a_fwd_data, 32'h22);
`else
        check("fwd_hit_off", a_fwd_hit, 1'b0);
        check("fwd_data_off", a_fwd_data, 32'h0);
`endif
        a_fwd_rs = 4'd0;
        #1;
        check("fwd_rs0", a_fwd_hit, 1'b0);
        a_fwd_rs = 4'd7;
        a_out_ready = 4'b0001;
        tick();
        a_out_ready = 4'b0000;
`ifdef EXE_WB_PIPE_FWD_EN
        check("fwd_data_l2", a_fwd_data, 32'h11);
`else
        check("fwd_data_l2_off", a_fwd_data, 32'h0);
`endif
        a_fwd_rs = 4'd6;
        #1;
        check("fwd_miss", a_fwd_hit, 1'b0);

        // ---------- reset overrides in-flight traffic ----------
        a_in_valid = 4'b1111;
        a_out_ready = 4'b1111;
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid_now", a_out_valid, 4'h0);
        tick();
        check("rst_mid_ready", a_in_ready, 4'h0);
        a_in_valid = 4'b0000;
        a_out_ready = 4'b0000;
        rst_n = 1'b1;
        #1;
        check("rst_mid_empty", a_out_valid, 4'h0);
        check("rst_mid_data", a_out_data, 128'h0);

        // ---------- random traffic, LANES=6 DW=16 ----------
        rst_b_n = 1'b1;
        for (int c = 0; c < 600; c++) begin
            for (int l = 0; l < 6; l++) begin
                b_in_valid[l]  = ($urandom_range(0, 99) < 60);
                b_out_ready[l] = ($urandom_range(0, 99) < 50);
                b_flush[l]     = ($urandom_range(0, 99) < 3);
                b_in_rd [l*4 +: 4]   = 4'($urandom);
                b_in_rs1[l*4 +: 4]   = 4'($urandom);
                b_in_rs2[l*4 +: 4]   = 4'($urandom);
                b_in_data[l*16 +: 16] = 16'($urandom);
            end
            #1;
            for (int l = 0; l < 6; l++) begin
                check($sformatf("rnd_valid_l%0d", l), b_out_valid[l], sb[l].size() > 0);
                check($sformatf("rnd_ready_l%0d", l), b_in_ready[l], sb[l].size() < 2);
                got_e = {b_out_rd[l*4 +: 4], b_out_rs1[l*4 +: 4],
                         b_out_rs2[l*4 +: 4], b_out_data[l*16 +: 16]};
                exp_e = (sb[l].size() > 0) ? sb[l][0] : 28'h0;
                check($sformatf("rnd_head_l%0d", l), got_e, exp_e);
                if (b_flush[l]) begin
                    sb[l].delete();
                end else begin
                    if (b_out_ready[l] && sb[l].size() > 0)
                        void'(sb[l].pop_front());
                    if (b_in_valid[l] && b_in_ready[l])
                        sb[l].push_back({b_in_rd[l*4 +: 4], b_in_rs1[l*4 +: 4],
                                         b_in_rs2[l*4 +: 4], b_in_data[l*16 +: 16]});
                end
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
